// File: rtl/regfile_pkg.sv
// regfile_pkg: shared sizes, the hardwired-zero register index and the arbiter state encoding.
package regfile_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREGS = 32;
    localparam logic [4:0] REG_ZERO = 5'd0;
    typedef enum logic {INIT, RUN} state_t;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter; bit 0 = A, bit 1 = B.
// The pointer remembers who was granted last and resets to B so that A wins the first tie.
module rr_arbiter2 (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] req,
    output logic [1:0] grant
);
    logic last_b;
    always_comb grant = (req == 2'b11) ? (last_b ? 2'b01 : 2'b10) : req;
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) last_b <= 1'b1;
        else if (|grant) last_b <= grant[1];
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: owns the registerfile write port; zero-sweeps after reset, then
// round-robin shares it between two single-entry hold buffers and exports a pending-write map.
module regfile_write_arbiter #(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W,
    parameter int NREGS = regfile_pkg::NREGS,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_reg,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_reg,
    input  logic [DATA_W-1:0] b_data,
    output logic              regwrite,
    output logic [ADDR_W-1:0] writereg,
    output logic [DATA_W-1:0] writedata,
    output logic              init_done,
    output logic [NREGS-1:0]  busy
);
    import regfile_pkg::*;
    localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NREGS - 1);
    state_t state, state_next;
    logic [ADDR_W-1:0] sweep, reg_a, reg_b, sel_reg;
    logic [DATA_W-1:0] data_a, data_b, sel_data;
    logic held_a, held_b, run, acc_a, acc_b;
    logic [1:0] grant;

    rr_arbiter2 u_arb (
        .clock(clock),
        .reset_n(reset_n),
        .req({held_b, held_a}),
        .grant(grant)
    );

    always_comb begin
        state_next = (state == INIT && sweep == LAST_REG) ? RUN : state;
        run = state == RUN;
        a_ready = run & (~held_a | grant[0]);
        b_ready = run & (~held_b | grant[1]);
        acc_a = a_valid & a_ready;
        acc_b = b_valid & b_ready;
        sel_reg = grant[1] ? reg_b : reg_a;
        sel_data = grant[1] ? data_b : data_a;
        busy = '0;
        if (held_a) busy[reg_a] = 1'b1;
        if (held_b) busy[reg_b] = 1'b1;
        if (regwrite) busy[writereg] = 1'b1;
        busy[0] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) state <= CLEAR_ON_RESET ? INIT : RUN;
        else state <= state_next;

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            held_a <= 1'b0;
            held_b <= 1'b0;
            reg_a <= '0;
            reg_b <= '0;
            data_a <= '0;
            data_b <= '0;
            sweep <= '0;
            regwrite <= 1'b0;
            writereg <= '0;
            writedata <= '0;
            init_done <= 1'b0;
        end else begin
            // a granted buffer may be refilled on the same edge it drains
            if (acc_a) begin
                held_a <= 1'b1;
                reg_a <= a_reg;
                data_a <= a_data;
            end else if (grant[0]) held_a <= 1'b0;
            if (acc_b) begin
                held_b <= 1'b1;
                reg_b <= b_reg;
                data_b <= b_data;
            end else if (grant[1]) held_b <= 1'b0;
            if (!run) begin
                regwrite <= 1'b1;
                writereg <= sweep;
                writedata <= '0;
                sweep <= sweep + 1'b1;
                init_done <= state_next == RUN;
            end else begin
                init_done <= 1'b1;
                // $0 requests still drain the buffer but never strobe the registerfile
                regwrite <= |grant && sel_reg != ADDR_W'(REG_ZERO);
                if (|grant) begin
                    writereg <= sel_reg;
                    writedata <= sel_data;
                end
            end
        end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed and random stimulus checked against a behavioural model
// of the sweep, hold buffers, round-robin grants and the pending-write map.
module tb_regfile_write_arbiter;
    logic clock = 1'b0, reset_n = 1'b0, a_valid = 1'b0, b_valid = 1'b0;
    logic [4:0] a_reg = '0, b_reg = '0, writereg;
    logic [31:0] a_data = '0, b_data = '0, writedata, busy;
    logic a_ready, b_ready, regwrite, init_done;
    int vectors = 0, miscompares = 0;

    bit m_init, m_ha, m_hb, m_lastb, m_rw, m_done, last_acc_a, last_acc_b;
    int m_cnt;
    logic [4:0] m_ra, m_rb, m_wr;
    logic [31:0] m_da, m_db, m_wd;
    logic [31:0] dut_rf [32];

    regfile_write_arbiter dut (
        .clock(clock), .reset_n(reset_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
        .regwrite(regwrite), .writereg(writereg), .writedata(writedata),
        .init_done(init_done), .busy(busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) if (regwrite) dut_rf[writereg] <= writedata;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        m_init = 1'b1; m_cnt = 0; m_ha = 1'b0; m_hb = 1'b0; m_lastb = 1'b1;
        m_rw = 1'b0; m_wr = '0; m_wd = '0; m_done = 1'b0;
    endfunction

    task automatic step();
        bit ga, gb, ra, rb;
        logic [31:0] eb;
        #1;
        ga = m_ha && (!m_hb || m_lastb);
        gb = m_hb && (!m_ha || !m_lastb);
        ra = !m_init && (!m_ha || ga);
        rb = !m_init && (!m_hb || gb);
        eb = '0;
        if (m_ha) eb[m_ra] = 1'b1;
        if (m_hb) eb[m_rb] = 1'b1;
        if (m_rw) eb[m_wr] = 1'b1;
        eb[0] = 1'b0;
        chk("a_ready", a_ready, ra);
        chk("b_ready", b_ready, rb);
        chk("regwrite", regwrite, m_rw);
        chk("writereg", writereg, m_wr);
        chk("writedata", writedata, m_wd);
        chk("init_done", init_done, m_done);
        chk("busy", busy, eb);
        last_acc_a = a_valid && ra;
        last_acc_b = b_valid && rb;
        @(posedge clock);
        if (m_init) begin
            m_rw = 1'b1; m_wr = 5'(m_cnt); m_wd = '0;
            if (m_cnt == 31) begin m_init = 1'b0; m_done = 1'b1; end
            m_cnt++;
        end else if (ga || gb) begin
            m_wr = gb ? m_rb : m_ra;
            m_wd = gb ? m_db : m_da;
            m_rw = m_wr != 0;
            m_lastb = gb;
        end else m_rw = 1'b0;
        if (last_acc_a) begin m_ha = 1'b1; m_ra = a_reg; m_da = a_data; end
        else if (ga) m_ha = 1'b0;
        if (last_acc_b) begin m_hb = 1'b1; m_rb = b_reg; m_db = b_data; end
        else if (gb) m_hb = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        int wq[$];
        bit found;
        m_reset();
        repeat (2) @(negedge clock);
        #1;
        chk("rst_regwrite", regwrite, 0);
        chk("rst_writereg", writereg, 0);
        chk("rst_writedata", writedata, 0);
        chk("rst_init_done", init_done, 0);
        reset_n = 1'b1;
        step();
        for (int k = 0; k < 32; k++) begin
            chk("sweep_reg", writereg, k);
            chk("sweep_done", init_done, k == 31);
            step();
        end
        chk("sweep_zeroed_r5", dut_rf[5], 0);

        a_valid = 1'b1; a_reg = 5'd5; a_data = 32'hDEADBEEF;
        step();
        a_valid = 1'b0;
        chk("single_busy_held", busy[5], 1);
        step();
        chk("single_regwrite", regwrite, 1);
        chk("single_writereg", writereg, 5);
        chk("single_writedata", writedata, 32'hDEADBEEF);
        chk("single_busy_out", busy[5], 1);
        step();
        chk("single_readback", dut_rf[5], 32'hDEADBEEF);
        chk("single_busy_clear", busy[5], 0);

        b_valid = 1'b1; b_reg = 5'd0; b_data = 32'hFFFFFFFF;
        step();
        chk("zero_b_accepted", last_acc_b, 1);
        b_valid = 1'b0;
        repeat (3) begin
            step();
            chk("zero_regwrite", regwrite, 0);
            chk("zero_busy0", busy[0], 0);
        end
        chk("zero_rf0", dut_rf[0], 0);

        a_valid = 1'b1; a_reg = 5'd1; a_data = 32'h100;
        b_valid = 1'b1; b_reg = 5'd2; b_data = 32'h200;
        for (int i = 0; i < 10; i++) begin
            step();
            if (last_acc_a) a_data++;
            if (last_acc_b) b_data++;
            if (regwrite) wq.push_back(int'(writereg));
        end
        chk("cont_w0", wq[0], 1);
        chk("cont_w1", wq[1], 2);
        chk("cont_w2", wq[2], 1);
        chk("cont_w3", wq[3], 2);

        a_reg = 5'd7; a_data = 32'hDEAD0005; b_reg = 5'd3;
        found = 1'b0;
        for (int i = 0; i < 4 && !found; i++) begin
            step();
            found = last_acc_a;
            if (last_acc_b) b_data++;
        end
        chk("bp_accepted", found, 1);
        a_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 2 && !found; i++) begin
            step();
            if (last_acc_b) b_data++;
            if (regwrite && writereg == 5'd7) begin
                found = 1'b1;
                chk("bp_data", writedata, 32'hDEAD0005);
            end
        end
        chk("bp_within_2", found, 1);
        b_valid = 1'b0;
        repeat (3) step();

        for (int i = 0; i < 300; i++) begin
            a_valid = 1'($urandom); a_reg = 5'($urandom); a_data = $urandom;
            b_valid = 1'($urandom); b_reg = 5'($urandom); b_data = $urandom;
            step();
        end

        a_valid = 1'b1; a_reg = 5'd9; a_data = 32'h9;
        b_valid = 1'b1; b_reg = 5'd10; b_data = 32'hA;
        repeat (2) step();
        a_valid = 1'b0; b_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_regwrite", regwrite, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_a_ready", a_ready, 0);
        chk("midrst_init_done", init_done, 0);
        m_reset();
        @(negedge clock);
        reset_n = 1'b1;
        step();
        chk("resweep_first_rw", regwrite, 1);
        chk("resweep_first_reg", writereg, 0);
        repeat (34) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
